// File: rtl/demux_16_buf.sv
// Buffered 1-to-16 demux: one holding register per lane, word visible the cycle after push.
// in_ready drops only when the selected lane is full and not draining; lanes stall independently.
module demux_16_buf #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_select,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic [15:0]              out_valid,
  input  logic [15:0]              out_ready,
  output logic [16*DATA_WIDTH-1:0] out_data,
  output logic [4:0]               occupancy
);

  logic [15:0]           full_q, full_d;
  logic [DATA_WIDTH-1:0] buf_q [16];
  logic [DATA_WIDTH-1:0] buf_d [16];
  logic [4:0]            occ_q, occ_d;
  logic                  push;

  // Pass-through: a full lane that is being popped can accept a new word in the same cycle.
  assign in_ready = ~full_q[in_select] | out_ready[in_select];
  assign push     = in_valid & in_ready;

  always_comb begin
    full_d = full_q;
    occ_d  = '0;
    for (int k = 0; k < 16; k++) begin
      buf_d[k] = buf_q[k];
      if (push && (in_select == 4'(k))) begin
        buf_d[k]  = in_data;
        full_d[k] = 1'b1;
      end else if (full_q[k] && out_ready[k]) begin
        full_d[k] = 1'b0;
      end
    end
    for (int k = 0; k < 16; k++) begin
      occ_d = occ_d + {4'b0000, full_d[k]};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      full_q <= '0;
      occ_q  <= '0;
      for (int k = 0; k < 16; k++) begin
        buf_q[k] <= '0;
      end
    end else begin
      full_q <= full_d;
      occ_q  <= occ_d;
      for (int k = 0; k < 16; k++) begin
        buf_q[k] <= buf_d[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 16; k++) begin
      out_data[k*DATA_WIDTH +: DATA_WIDTH] = buf_q[k];
    end
  end

  assign out_valid = full_q;
  assign occupancy = occ_q;

endmodule
